// File: rtl/vga_sync_scheduler_if.sv
// Frame-buffer update handshake between the game logic and the VGA scheduler.
// The game logic is the master (raises requests); the scheduler is the slave
// (opens and closes the update window).
interface vga_sync_scheduler_if;
    logic upd_req;    // level request for an update window
    logic upd_done;   // one-clock release of the window by the requester
    logic upd_grant;  // window open
    logic upd_abort;  // one-clock pulse: window forcibly closed at frame start

    modport master (
        output upd_req,
        output upd_done,
        input  upd_grant,
        input  upd_abort
    );

    modport slave (
        input  upd_req,
        input  upd_done,
        output upd_grant,
        output upd_abort
    );
endinterface

// File: rtl/vga_sync_scheduler.sv
// Pixel-rate scheduler for the VGA path: pixel-enable divider, h/v scan
// counters with registered sync/blank decode, and a vblank-only arbiter that
// hands the frame buffer to the game logic once per vertical blank.
module vga_sync_scheduler #(
    parameter int DIVISOR   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 enable,
    vga_sync_scheduler_if.slave  upd,
    output logic                 pixel_tick,
    output logic [9:0]           pixel_x,
    output logic [9:0]           pixel_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic                 frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SERVED = 2'd2
    } arb_state_e;

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          hsync_q, vsync_q, video_on_q, frame_start_q;
    logic          tick;
    logic          wrap;
    logic          vblank_d;

    arb_state_e    state_q;
    logic          grant_q;
    logic          abort_q;

    // Tick, next-state counters and the frame-wrap / grant-window decode.
    always_comb begin
        tick     = enable && (div_q == DIV_LAST);
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        wrap     = tick && (h_q == H_LAST) && (v_q == V_LAST);
        // Grant window excludes the last line so a grant always has at least
        // one full line before the frame-start abort point.
        vblank_d = (v_d >= 10'(V_VISIBLE)) && (v_d <= 10'(V_TOTAL - 2));
    end

    // Divider, scan counters and decoded video outputs; all hold while enable=0.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= !((h_d >= 10'(HS_START)) && (h_d < 10'(HS_END)));
            vsync_q       <= !((v_d >= 10'(VS_START)) && (v_d < 10'(VS_END)));
            video_on_q    <= (h_d < 10'(H_VISIBLE)) && (v_d < 10'(V_VISIBLE));
            frame_start_q <= wrap;
        end
    end

    // Update-window arbiter: one grant per vblank, aborted if still open at frame start.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            abort_q <= 1'b0;
        end else if (enable) begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick && upd.upd_req && vblank_d) begin
                        state_q <= GRANT;
                        grant_q <= 1'b1;
                    end
                end
                GRANT: begin
                    // A release landing on the wrap tick counts as served.
                    if (wrap) begin
                        state_q <= IDLE;
                        grant_q <= 1'b0;
                        abort_q <= !upd.upd_done;
                    end else if (upd.upd_done) begin
                        state_q <= SERVED;
                        grant_q <= 1'b0;
                    end
                end
                SERVED: begin
                    if (wrap) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    // Pulses stay registered across a freeze but are masked until sequencing resumes.
    assign pixel_tick    = tick;
    assign frame_start   = frame_start_q & enable;
    assign upd.upd_abort = abort_q & enable;
    assign upd.upd_grant = grant_q;
    assign pixel_x       = h_q;
    assign pixel_y       = v_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign video_on      = video_on_q;

endmodule

// File: tb/tb_vga_sync_scheduler.sv
// Directed bench for vga_sync_scheduler on a shrunken raster:
// H 8/2/3/2 (total 15, hsync low at x 10..12), V 6/1/2/2 (total 11, vsync
// low on lines 7..8, grant window lines 6..9), DIVISOR 2 -> 330 clocks/frame.
module tb_vga_sync_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tick, hs, vs, von, fs;
    logic [9:0] px, py;

    int n_tests = 0;
    int n_fail  = 0;
    int kcnt    = 0;

    vga_sync_scheduler_if u_if ();

    vga_sync_scheduler #(
        .DIVISOR(2),
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .enable     (en),
        .upd        (u_if),
        .pixel_tick (tick),
        .pixel_x    (px),
        .pixel_y    (py),
        .hsync      (hs),
        .vsync      (vs),
        .video_on   (von),
        .frame_start(fs)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(int k, logic t, int x, int y, logic h, logic v,
                                logic o, logic f);
        vec_t r;
        r.k = k; r.tick = t; r.x = 10'(x); r.y = 10'(y);
        r.hs = h; r.vs = v; r.von = o; r.fs = f;
        return r;
    endfunction

    function automatic logic [26:0] obs();
        return {tick, px, py, hs, vs, von, fs, u_if.upd_grant, u_if.upd_abort};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        kcnt++;
    endtask

    // kind 0: (x,y) in a tick cycle; 1: grant high; 2: frame_start; 3: line y reached
    task automatic run_until(input int kind, input int tx, input int ty, input string nm,
                             output int ncyc, output int gcnt);
        logic hit;
        hit  = 1'b0;
        ncyc = 0;
        gcnt = 0;
        while (!hit && ncyc < 800) begin
            step();
            ncyc++;
            if (u_if.upd_grant) gcnt++;
            case (kind)
                0:       hit = tick && (px == 10'(tx)) && (py == 10'(ty));
                1:       hit = u_if.upd_grant;
                2:       hit = fs;
                default: hit = (py == 10'(ty));
            endcase
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, expected event", nm, ncyc);
        end
    endtask

    initial begin
        logic [26:0] snap, expv;
        int nc, gc, mism;
        int hs_lo, vs_lo, von_hi, vs_bad, hs_bad, von_bad;

        tbl[0]  = mk(0,   0, 14, 10, 1, 1, 0, 0);
        tbl[1]  = mk(1,   1, 14, 10, 1, 1, 0, 0);
        tbl[2]  = mk(2,   0,  0,  0, 1, 1, 1, 1);
        tbl[3]  = mk(3,   1,  0,  0, 1, 1, 1, 0);
        tbl[4]  = mk(4,   0,  1,  0, 1, 1, 1, 0);
        tbl[5]  = mk(16,  0,  7,  0, 1, 1, 1, 0);
        tbl[6]  = mk(18,  0,  8,  0, 1, 1, 0, 0);
        tbl[7]  = mk(22,  0, 10,  0, 0, 1, 0, 0);
        tbl[8]  = mk(26,  0, 12,  0, 0, 1, 0, 0);
        tbl[9]  = mk(28,  0, 13,  0, 1, 1, 0, 0);
        tbl[10] = mk(32,  0,  0,  1, 1, 1, 1, 0);
        tbl[11] = mk(182, 0,  0,  6, 1, 1, 0, 0);
        tbl[12] = mk(212, 0,  0,  7, 1, 0, 0, 0);
        tbl[13] = mk(240, 0, 14,  7, 1, 0, 0, 0);
        tbl[14] = mk(268, 0, 13,  8, 1, 0, 0, 0);
        tbl[15] = mk(272, 0,  0,  9, 1, 1, 0, 0);
        tbl[16] = mk(330, 0, 14, 10, 1, 1, 0, 0);
        tbl[17] = mk(331, 1, 14, 10, 1, 1, 0, 0);
        tbl[18] = mk(332, 0,  0,  0, 1, 1, 1, 1);

        rst_n = 1'b0;
        en = 1'b1;
        u_if.upd_req = 1'b0;
        u_if.upd_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // First frame at fixed clock counts from reset release
        for (int i = 0; i < 19; i++) begin
            while (kcnt < tbl[i].k) step();
            expv = {tbl[i].tick, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
                    tbl[i].von, tbl[i].fs, 1'b0, 1'b0};
            chk($sformatf("vec%0d_k%0d", i, tbl[i].k), 32'(obs()), 32'(expv));
        end

        // Full second frame: decode statistics and frame period
        hs_lo = 0; vs_lo = 0; von_hi = 0; vs_bad = 0; hs_bad = 0; von_bad = 0; nc = 0;
        do begin
            step();
            nc++;
            if (tick) begin
                if (!hs) hs_lo++;
                if (!vs) vs_lo++;
                if (von) von_hi++;
                if (!vs && !(py == 10'd7 || py == 10'd8)) vs_bad++;
                if (hs != !(px >= 10'd10 && px <= 10'd12)) hs_bad++;
                if (von != (px < 10'd8 && py < 10'd6)) von_bad++;
            end
        end while (!fs && nc < 400);
        chk("frame_period", 32'(nc), 32'd330);
        chk("hsync_low_ticks", 32'(hs_lo), 32'd33);
        chk("vsync_low_ticks", 32'(vs_lo), 32'd30);
        chk("video_on_ticks", 32'(von_hi), 32'd48);
        chk("vsync_wrong_line", 32'(vs_bad), 32'd0);
        chk("hsync_decode", 32'(hs_bad), 32'd0);
        chk("video_on_decode", 32'(von_bad), 32'd0);

        // Freeze for 37 cycles in the tick cycle of x=5
        run_until(0, 5, 0, "wait_x5", nc, gc);
        en = 1'b0;
        #1;
        chk("freeze_tick_low", 32'(tick), 32'd0);
        snap = obs();
        mism = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (obs() !== snap) mism++;
        end
        chk("freeze_hold", 32'(mism), 32'd0);
        en = 1'b1;
        #1;
        chk("resume_tick", 32'({tick, px}), 32'({1'b1, 10'd5}));
        step();
        chk("resume_adv", 32'({tick, px}), 32'({1'b0, 10'd6}));
        step();
        chk("resume_phase", 32'(tick), 32'd1);

        // Normal update: grant at (0,6), release on line 7, no re-grant
        u_if.upd_req = 1'b1;
        run_until(1, 0, 0, "wait_grant1", nc, gc);
        chk("grant1_pos", 32'({px, py}), 32'({10'd0, 10'd6}));
        run_until(0, 3, 7, "wait_line7", nc, gc);
        u_if.upd_done = 1'b1;
        step();
        u_if.upd_done = 1'b0;
        #1;
        chk("done_closes", 32'(u_if.upd_grant), 32'd0);
        run_until(2, 0, 0, "wait_fs1", nc, gc);
        chk("no_regrant", 32'(gc), 32'd0);
        chk("served_no_abort", 32'(u_if.upd_abort), 32'd0);

        // Overrun: grant never released is aborted at frame start
        run_until(1, 0, 0, "wait_grant2", nc, gc);
        chk("grant2_pos", 32'({px, py}), 32'({10'd0, 10'd6}));
        run_until(2, 0, 0, "wait_fs2", nc, gc);
        chk("overrun_abort", 32'({u_if.upd_grant, u_if.upd_abort}), 32'({1'b0, 1'b1}));
        step();
        chk("abort_one_cycle", 32'(u_if.upd_abort), 32'd0);

        // Release coinciding with the wrap tick: served, no abort
        run_until(1, 0, 0, "wait_grant3", nc, gc);
        run_until(0, 14, 10, "wait_last_px", nc, gc);
        u_if.upd_done = 1'b1;
        step();
        u_if.upd_done = 1'b0;
        #1;
        chk("wrap_done", 32'({fs, u_if.upd_grant, u_if.upd_abort}), 32'({1'b1, 1'b0, 1'b0}));

        // Late request on the last line waits for the next vblank
        u_if.upd_req = 1'b0;
        run_until(3, 0, 10, "wait_line10", nc, gc);
        u_if.upd_req = 1'b1;
        run_until(2, 0, 0, "wait_fs3", nc, gc);
        chk("late_no_grant", 32'(gc), 32'd0);
        run_until(1, 0, 0, "wait_grant4", nc, gc);
        chk("late_grant_pos", 32'({px, py}), 32'({10'd0, 10'd6}));

        // Asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        chk("reset_grant", 32'(u_if.upd_grant), 32'd0);
        chk("reset_pos", 32'({px, py}), 32'({10'd14, 10'd10}));
        chk("reset_levels", 32'({tick, hs, vs, von, fs, u_if.upd_abort}),
            32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
